// File: rtl/adain_sched_pkg.sv
// rtl/adain_sched_pkg.sv - shared state encoding and core command codes for adain_sched
package adain_sched_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ST_ISSUE,
    ST_WAIT,
    NM_ISSUE,
    NM_RUN,
    NEXT,
    DRAIN
  } state_t;

  localparam logic [1:0] START_NONE = 2'b00;
  localparam logic [1:0] START_STAT = 2'b01;
  localparam logic [1:0] START_NORM = 2'b10;

  localparam logic [1:0] DONE_STAT  = 2'd1;
  localparam logic [1:0] DONE_PIXEL = 2'd2;

  // Cycles core_done is ignored after a stats issue, and settle cycles after the last pixel.
  localparam int BLANK_CYCLES = 2;
  localparam int GUARD_CYCLES = 2;

endpackage

// File: rtl/adain_sched_if.sv
// rtl/adain_sched_if.sv - output pixel stream with valid/ready handshake
interface adain_sched_if #(
  parameter int DW = 16
) ();
  logic          m_valid;
  logic          m_ready;
  logic [DW-1:0] m_data;

  modport master (output m_valid, output m_data, input m_ready);
  modport slave  (input m_valid, input m_data, output m_ready);
endinterface

// File: rtl/adain_sched_fifo.sv
// rtl/adain_sched_fifo.sv - synchronous FIFO buffering core output pixels
module sync_fifo #(
  parameter int W     = 16,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [W-1:0]               din,
  input  logic                       pop,
  output logic [W-1:0]               dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  // A pop frees the head slot in the same cycle, so a push into a full FIFO is accepted then.
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/adain_sched.sv
// rtl/adain_sched.sv - per-channel AdaIN job sequencer: stats, normalize, buffered pixel output
module adain_sched
  import adain_sched_pkg::*;
#(
  parameter int N_MAX      = 128,
  parameter int C_MAX      = 512,
  parameter int DW         = 16,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [$clog2(N_MAX+1)-1:0]   cfg_n,
  input  logic [$clog2(C_MAX+1)-1:0]   cfg_c,
  input  logic                         go,
  output logic                         busy,
  output logic                         job_done,
  output logic                         err_ovf,
  output logic [1:0]                   core_start,
  output logic [$clog2(N_MAX+1)-1:0]   core_n,
  input  logic [1:0]                   core_done,
  input  logic                         core_out_en,
  input  logic [DW-1:0]                core_out_data,
  output logic [$clog2(C_MAX)-1:0]     ch_idx,
  adain_sched_if.master                m
);
  localparam int NW = $clog2(N_MAX+1);
  localparam int CW = $clog2(C_MAX+1);
  localparam int IW = $clog2(C_MAX);
  localparam int PW = 2*NW;

  state_t                    state, state_nx;
  logic [NW-1:0]             n_q;
  logic [CW-1:0]             c_q;
  logic [IW-1:0]             ch_q;
  logic [PW-1:0]             pix_cnt;
  logic [PW-1:0]             pix_total;
  logic [1:0]                blank_cnt;
  logic [1:0]                guard_cnt;
  logic                      ovf_q;

  logic                      fifo_full;
  logic                      fifo_empty;
  logic                      fifo_pop;
  logic                      fifo_drop;
  logic                      fifo_idle;
  logic [$clog2(FIFO_DEPTH):0] fifo_cnt;

  logic                      go_ok;
  logic                      last_ch;
  logic                      blank_over;
  logic                      pix_all;

  sync_fifo #(
    .W     (DW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (core_out_en),
    .din   (core_out_data),
    .pop   (fifo_pop),
    .dout  (m.m_data),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_cnt)
  );

  assign m.m_valid  = !fifo_empty;
  assign fifo_pop   = m.m_valid && m.m_ready;
  assign fifo_drop  = core_out_en && fifo_full && !fifo_pop;
  assign fifo_idle  = (fifo_cnt == '0);

  assign go_ok      = go && (cfg_n >= NW'(2)) && (cfg_c >= CW'(1));
  assign last_ch    = (CW'(ch_q) == c_q - CW'(1));
  assign pix_total  = PW'(n_q) * PW'(n_q);
  assign blank_over = (blank_cnt == 2'(BLANK_CYCLES));
  assign pix_all    = (pix_cnt == pix_total);

  assign busy    = (state != IDLE);
  assign err_ovf = ovf_q;
  assign core_n  = n_q;
  assign ch_idx  = ch_q;

  always_comb begin
    state_nx   = state;
    core_start = START_NONE;
    job_done   = 1'b0;
    case (state)
      IDLE:     if (go_ok) state_nx = ST_ISSUE;
      ST_ISSUE: begin
        core_start = START_STAT;
        state_nx   = ST_WAIT;
      end
      // A done level left over from the previous channel is masked until blanking expires.
      ST_WAIT:  if (blank_over && core_done == DONE_STAT) state_nx = NM_ISSUE;
      NM_ISSUE: if (fifo_idle) begin
        core_start = START_NORM;
        state_nx   = NM_RUN;
      end
      NM_RUN:   if (pix_all && guard_cnt == 2'(GUARD_CYCLES-1)) state_nx = NEXT;
      NEXT:     state_nx = last_ch ? DRAIN : ST_ISSUE;
      DRAIN:    if (fifo_idle) begin
        job_done = 1'b1;
        state_nx = IDLE;
      end
      default:  state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      n_q       <= '0;
      c_q       <= '0;
      ch_q      <= '0;
      pix_cnt   <= '0;
      blank_cnt <= '0;
      guard_cnt <= '0;
      ovf_q     <= 1'b0;
    end else begin
      state <= state_nx;

      if (state == IDLE && go_ok) begin
        n_q  <= cfg_n;
        c_q  <= cfg_c;
        ch_q <= '0;
      end else if (state == NEXT && !last_ch) begin
        ch_q <= ch_q + 1'b1;
      end

      if (state == ST_ISSUE) blank_cnt <= '0;
      else if (state == ST_WAIT && !blank_over) blank_cnt <= blank_cnt + 1'b1;

      if (state != NM_RUN && state_nx == NM_RUN) begin
        pix_cnt   <= '0;
        guard_cnt <= '0;
      end else if (state == NM_RUN) begin
        if (!pix_all) begin
          if (core_out_en) pix_cnt <= pix_cnt + 1'b1;
        end else begin
          guard_cnt <= guard_cnt + 1'b1;
        end
      end

      if (state == IDLE && go_ok) ovf_q <= 1'b0;
      else if (fifo_drop)         ovf_q <= 1'b1;
    end
  end
endmodule

// File: tb/tb_adain_sched.sv
// tb/tb_adain_sched.sv - randomized scoreboard bench for adain_sched with a behavioural core model
module tb_adain_sched;
  localparam int N_MAX = 8;
  localparam int C_MAX = 4;
  localparam int DW    = 16;
  localparam int DEPTH = 16;
  localparam int NW    = $clog2(N_MAX+1);
  localparam int CW    = $clog2(C_MAX+1);
  localparam int IW    = $clog2(C_MAX);
  localparam int STAT_LAT = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [NW-1:0] cfg_n;
  logic [CW-1:0] cfg_c;
  logic          go;
  logic          busy, job_done, err_ovf;
  logic [1:0]    core_start;
  logic [NW-1:0] core_n;
  logic [1:0]    core_done;
  logic          core_out_en;
  logic [DW-1:0] core_out_data;
  logic [IW-1:0] ch_idx;

  adain_sched_if #(.DW(DW)) m_if ();

  always #5 clk = ~clk;

  adain_sched #(
    .N_MAX(N_MAX), .C_MAX(C_MAX), .DW(DW), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst_n(rst_n), .cfg_n(cfg_n), .cfg_c(cfg_c), .go(go),
    .busy(busy), .job_done(job_done), .err_ovf(err_ovf),
    .core_start(core_start), .core_n(core_n), .core_done(core_done),
    .core_out_en(core_out_en), .core_out_data(core_out_data),
    .ch_idx(ch_idx), .m(m_if.master)
  );

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] next_pix = 16'h0011;
  int  job_n = 0, model_chan = 0, n_stat = 0, n_norm = 0, done_cnt = 0;
  int  stat_h = 0, stat_t = 0, pix_left = 0, chan_pushed = 0;
  bit  block_all = 0, norm_block = 0, release_pending = 0, rdy_full = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Core model: stats take STAT_LAT cycles after a stale done level held two extra cycles;
  // normalize emits N*N sequential pixels with random gaps. In blocked mode only the first
  // DEPTH pixels of a channel can be kept, since the FIFO is empty when normalize starts.
  initial begin
    core_done = 2'd0; core_out_en = 1'b0; core_out_data = '0; m_if.m_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      core_out_en = 1'b0;
      if (!rst_n) begin
        stat_h = 0; stat_t = 0; pix_left = 0; norm_block = 0; release_pending = 0;
        core_done = 2'd0;
        exp_q.delete();
      end else begin
        if (release_pending) begin norm_block = 0; release_pending = 0; end
        if (core_start == 2'b01) begin
          check("ch_idx_at_stat", 32'(ch_idx), model_chan);
          check("core_n", 32'(core_n), job_n);
          check("stat_after_pixels", pix_left, 0);
          model_chan++; n_stat++;
          stat_h = 2; stat_t = STAT_LAT;
        end else if (core_start == 2'b10) begin
          check("norm_after_stats", 32'(stat_h == 0 && stat_t == 0 && core_done == 2'd1), 1);
          check("ch_idx_at_norm", 32'(ch_idx), model_chan - 1);
          n_norm++; pix_left = job_n * job_n; chan_pushed = 0; norm_block = block_all;
          core_done = 2'd0;
        end else if (stat_h > 0) begin
          stat_h--;
        end else if (stat_t > 0) begin
          stat_t--;
          core_done = (stat_t == 0) ? 2'd1 : 2'd0;
        end else if (pix_left > 0 && $urandom_range(0, 3) != 0) begin
          core_out_en = 1'b1; core_out_data = next_pix;
          if (!norm_block || chan_pushed < DEPTH) exp_q.push_back(next_pix);
          chan_pushed++; next_pix++; pix_left--;
          core_done = 2'd2;
          if (pix_left == 0) begin core_done = 2'd1; release_pending = 1; end
        end
      end
      m_if.m_ready = norm_block ? 1'b0 : (rdy_full ? 1'b1 : 1'($urandom_range(0, 1)));
    end
  end

  initial begin
    logic [DW-1:0] e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (m_if.m_valid && m_if.m_ready) begin
          check("out_expected", 32'(exp_q.size() != 0), 1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("m_data", 32'(m_if.m_data), 32'(e));
          end
        end
        if (core_start == 2'b10) check("norm_fifo_empty", 32'(m_if.m_valid), 0);
        if (job_done) done_cnt++;
      end
    end
  end

  task automatic pulse_go(input int n, input int c);
    @(negedge clk);
    cfg_n = NW'(n); cfg_c = CW'(c); go = 1'b1;
    @(negedge clk);
    go = 1'b0;
  endtask

  task automatic run_job(input int n, input int c, input bit blk, input bit extra_go);
    int d0;
    job_n = n; model_chan = 0; n_stat = 0; n_norm = 0; block_all = blk;
    d0 = done_cnt;
    pulse_go(n, c);
    check("busy_on_go", 32'(busy), 1);
    check("ovf_cleared_on_go", 32'(err_ovf), 0);
    if (extra_go) begin
      repeat (4) @(negedge clk);
      pulse_go(2, C_MAX);
    end
    for (int i = 0; i < 5000 && done_cnt == d0; i++) @(negedge clk);
    check("job_done_seen", done_cnt - d0, 1);
    repeat (3) @(negedge clk);
    check("job_done_once", done_cnt - d0, 1);
    check("busy_after_job", 32'(busy), 0);
    check("stat_pulses", n_stat, c);
    check("norm_pulses", n_norm, c);
    check("exp_drained", exp_q.size(), 0);
    check("err_ovf", 32'(err_ovf), 32'(blk && (n * n > DEPTH)));
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_job_done"}, 32'(job_done), 0);
    check({tag, "_err_ovf"}, 32'(err_ovf), 0);
    check({tag, "_core_start"}, 32'(core_start), 0);
    check({tag, "_ch_idx"}, 32'(ch_idx), 0);
    check({tag, "_m_valid"}, 32'(m_if.m_valid), 0);
    check({tag, "_core_n"}, 32'(core_n), 0);
  endtask

  initial begin
    int found;
    rst_n = 1'b0; go = 1'b0; cfg_n = '0; cfg_c = '0;
    repeat (3) @(negedge clk);
    check_reset_values("reset");
    rst_n = 1'b1;

    rdy_full = 1;
    run_job(2, 1, 0, 0);
    rdy_full = 0;

    pulse_go(1, 1);
    check("go_bad_n_ignored", 32'(busy), 0);
    pulse_go(3, 0);
    check("go_bad_c_ignored", 32'(busy), 0);

    run_job(4, 3, 0, 1);
    run_job(4, 2, 1, 0);
    run_job(8, 2, 1, 0);
    run_job(3, 1, 0, 0);

    for (int k = 0; k < 6; k++)
      run_job($urandom_range(2, 4), $urandom_range(1, C_MAX), 0, 0);

    job_n = 4; model_chan = 0; n_stat = 0; n_norm = 0; block_all = 0;
    pulse_go(4, 3);
    found = 0;
    for (int i = 0; i < 5000 && found == 0; i++) begin
      @(negedge clk);
      if (n_norm >= 2 && pix_left > 0 && pix_left < 10) found = 1;
    end
    check("reset_window", found, 1);
    rst_n = 1'b0;
    @(negedge clk);
    check_reset_values("midrun_reset");
    rst_n = 1'b1;
    run_job(2, 2, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/adain_sched.md
ADAIN_SCHED -- requirements
Module: adain_sched

Interface
REQ-001 SHALL have parameter N_MAX, default 128, max feature-map side length.
REQ-002 SHALL have parameter C_MAX, default 512, max channel count.
REQ-003 SHALL have parameter DW, default 16, output pixel width.
REQ-004 SHALL have parameter FIFO_DEPTH, default 16, power of two, output buffer entries.
REQ-005 clk  in  1  sole clock; rising edge.
REQ-006 rst_n  in  1  reset; synchronous and active-low.
REQ-007 cfg_n  in  clog2(N_MAX+1)  side length N; sampled on go.
REQ-008 cfg_c  in  clog2(C_MAX+1)  channel count C; sampled on go.
REQ-009 go  in  1  one-cycle job start; ignored unless idle.
REQ-010 busy  out  1  job in progress.
REQ-011 job_done  out  1  one-cycle pulse when the last channel's last pixel leaves the FIFO.
REQ-012 err_ovf  out  1  sticky FIFO overflow flag.
REQ-013 core_start  out  2  to AdaIN core: 01 = statistics, 10 = normalize, 00 otherwise.
REQ-014 core_n  out  clog2(N_MAX+1)  latched N to core.
REQ-015 core_done  in  2  core status level: 1 = stats done, 2 = normalize pixel issued.
REQ-016 core_out_en  in  1  core output-valid strobe.
REQ-017 core_out_data  in  DW  core output pixel.
REQ-018 ch_idx  out  clog2(C_MAX)  current channel, selects input/style memories.
REQ-019 m_valid / m_ready / m_data  out/in/out  1/1/DW  output stream, valid/ready handshake.

Function
REQ-020 FSM states: IDLE, ST_ISSUE, ST_WAIT, NM_ISSUE, NM_RUN, NEXT, DRAIN.
REQ-021 IDLE: on go with cfg_n>=2 and cfg_c>=1, latch N and C, clear ch_idx, go to ST_ISSUE; otherwise stay idle.
REQ-022 ST_ISSUE: drive core_start=01 for exactly one cycle, then go to ST_WAIT.
REQ-023 ST_WAIT: ignore core_done for 2 cycles after issue (blanking), then go to NM_ISSUE on the first cycle core_done==1.
REQ-024 NM_ISSUE: wait until the FIFO is empty, then drive core_start=10 for one cycle and go to NM_RUN.
REQ-025 NM_RUN: count core_out_en pulses; at count N*N, after 2 guard cycles, go to NEXT.
REQ-026 The pixel counter SHALL be 2*clog2(N_MAX+1) bits wide and SHALL clear on entering NM_RUN.
REQ-027 NEXT: if ch_idx==C-1, go to DRAIN; otherwise increment ch_idx and go to ST_ISSUE.
REQ-028 DRAIN: when the FIFO is empty, pulse job_done and go to IDLE.
REQ-029 Every core_out_en pulse SHALL push core_out_data the same cycle.
- A push with the FIFO full drops the data and sets err_ovf.
- A simultaneous push and pop when full is legal and sets no flag.
REQ-030 m_valid SHALL be high iff the FIFO is non-empty; m_data is the head entry; a pop occurs when m_valid&&m_ready.
REQ-031 busy SHALL be high in every state except IDLE.
REQ-032 go while busy SHALL be ignored.
REQ-033 err_ovf SHALL clear only on reset or on an accepted go.
REQ-034 core_start SHALL be 00 in every cycle not named in REQ-022 or REQ-024.

Reset
REQ-035 While rst_n=0 at a clock edge, the block SHALL enter IDLE; any in-flight job is abandoned.
REQ-036 Reset values: core_start=00, ch_idx=0, busy=0, job_done=0, err_ovf=0, m_valid=0, FIFO pointers 0, counters 0, core_n=0.

Structure
REQ-037 A shared package SHALL hold the FSM state encoding and the core_start codes (START_STAT=01, START_NORM=10, START_NONE=00).
REQ-038 The output buffer SHALL be a single sub-module, sync_fifo, with full/empty flags and an occupancy count.

Verification
REQ-039 N=2, C=1, core model with 4-cycle stats and 4 pixels 0x0011..0x0014, m_ready=1 -> one 01 pulse, one 10 pulse, m_data 0x0011..0x0014 in order, job_done once.
REQ-040 N=4, C=3 -> ch_idx steps 0,1,2; three 01 and three 10 pulses; 48 outputs; no 10 pulse while the FIFO is non-empty.
REQ-041 N=4, m_ready=0 throughout normalize, FIFO_DEPTH=16 -> no err_ovf; the 17th pixel of the next channel is not issued until drained.
REQ-042 FIFO_DEPTH=4, N=4, m_ready=0 -> err_ovf=1 after the 5th pixel and stays set; cleared by the next go.
REQ-043 Stale core_done=1 still held from the prior channel -> blanking prevents early ST_WAIT exit; exit only after the core reasserts.
REQ-044 rst_n=0 mid-NM_RUN -> next cycle all outputs at reset values; a new go runs a clean job.
